// File: rtl/project_select_pkg.sv
// Shared definitions for the project selector: register map, field positions and FSM states.
package project_select_pkg;

    localparam int unsigned GuardW = 8;

    localparam logic [7:0] OffCtrl   = 8'h00;
    localparam logic [7:0] OffStatus = 8'h04;
    localparam logic [7:0] OffGuard  = 8'h08;

    localparam int unsigned CtrlSelLsb  = 0;
    localparam int unsigned CtrlSelW    = 4;
    localparam int unsigned CtrlEnBit   = 8;
    localparam int unsigned StatCurLsb  = 0;
    localparam int unsigned StatOnBit   = 8;
    localparam int unsigned StatBusyBit = 9;

    typedef enum logic [1:0] {
        StOff,
        StGuard,
        StOn
    } ps_state_e;

endpackage

// File: rtl/ps_wb_slave.sv
// Wishbone classic slave: address decode, single-cycle ack, registered readback and
// write strobes for the project selector register file.
module ps_wb_slave
    import project_select_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_ni,
    input  logic        wbs_stb_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_dat_i,
    input  logic [31:0] wbs_adr_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    input  logic [31:0] ctrl_rdata_i,
    input  logic [31:0] status_rdata_i,
    input  logic [31:0] guard_rdata_i,
    output logic        ctrl_we_o,
    output logic        guard_we_o,
    output logic [31:0] wdata_o
);

    logic        hit;
    logic        start;
    logic [7:0]  offset;
    logic [31:0] rdata;
    logic        ack_d, ack_q;
    logic [31:0] dat_d, dat_q;
    logic        unused_sel;

    assign unused_sel = ^wbs_sel_i;

    assign offset = wbs_adr_i[7:0];
    assign hit    = wbs_stb_i && wbs_cyc_i && (wbs_adr_i[31:8] == BASE_ADDR[31:8]);
    // A new transfer starts only while ack is low, so acks can never be back-to-back.
    assign start  = hit && !ack_q;

    always_comb begin
        rdata = '0;
        case (offset)
            OffCtrl:   rdata = ctrl_rdata_i;
            OffStatus: rdata = status_rdata_i;
            OffGuard:  rdata = guard_rdata_i;
            default:   rdata = '0;
        endcase
    end

    always_comb begin
        ack_d      = start;
        dat_d      = (start && !wbs_we_i) ? rdata : '0;
        ctrl_we_o  = start && wbs_we_i && (offset == OffCtrl);
        guard_we_o = start && wbs_we_i && (offset == OffGuard);
        wdata_o    = wbs_dat_i;
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            ack_q <= 1'b0;
            dat_q <= '0;
        end else begin
            ack_q <= ack_d;
            dat_q <= dat_d;
        end
    end

    assign wbs_ack_o = ack_q;
    assign wbs_dat_o = ack_q ? dat_q : '0;

endmodule

// File: rtl/project_select.sv
// Project selector: one-hot enable for up to 16 project wrappers with a break-before-make
// guard interval, controlled over Wishbone.
module project_select
    import project_select_pkg::*;
#(
    parameter int unsigned NUM_PROJECTS  = 8,
    parameter logic [31:0] BASE_ADDR     = 32'h3000_0000,
    parameter logic [7:0]  GUARD_DEFAULT = 8'd4
) (
    input  logic                    wb_clk_i,
    input  logic                    wb_rst_ni,
    input  logic                    wbs_stb_i,
    input  logic                    wbs_cyc_i,
    input  logic                    wbs_we_i,
    input  logic [3:0]              wbs_sel_i,
    input  logic [31:0]             wbs_dat_i,
    input  logic [31:0]             wbs_adr_i,
    output logic                    wbs_ack_o,
    output logic [31:0]             wbs_dat_o,
    output logic [NUM_PROJECTS-1:0] active_o
);

    logic                ctrl_we;
    logic                guard_we;
    logic [31:0]         wdata;
    logic [31:0]         ctrl_rdata;
    logic [31:0]         status_rdata;
    logic [31:0]         guard_rdata;
    logic                unused_wdata;

    logic [CtrlSelW-1:0] wr_sel;
    logic                wr_en;
    logic                wr_valid;

    ps_state_e           state_d, state_q;
    logic [GuardW-1:0]   cnt_d, cnt_q;
    logic [GuardW-1:0]   guard_d, guard_q;
    logic [CtrlSelW-1:0] ctrl_sel_d, ctrl_sel_q;
    logic                ctrl_en_d, ctrl_en_q;
    logic [CtrlSelW-1:0] cur_d, cur_q;
    logic [CtrlSelW-1:0] pend_d, pend_q;

    ps_wb_slave #(
        .BASE_ADDR(BASE_ADDR)
    ) u_wb_slave (
        .wb_clk_i      (wb_clk_i),
        .wb_rst_ni     (wb_rst_ni),
        .wbs_stb_i     (wbs_stb_i),
        .wbs_cyc_i     (wbs_cyc_i),
        .wbs_we_i      (wbs_we_i),
        .wbs_sel_i     (wbs_sel_i),
        .wbs_dat_i     (wbs_dat_i),
        .wbs_adr_i     (wbs_adr_i),
        .wbs_ack_o     (wbs_ack_o),
        .wbs_dat_o     (wbs_dat_o),
        .ctrl_rdata_i  (ctrl_rdata),
        .status_rdata_i(status_rdata),
        .guard_rdata_i (guard_rdata),
        .ctrl_we_o     (ctrl_we),
        .guard_we_o    (guard_we),
        .wdata_o       (wdata)
    );

    assign unused_wdata = ^{wdata[31:9], wdata[7:4]};

    assign wr_sel   = wdata[CtrlSelLsb +: CtrlSelW];
    assign wr_en    = wdata[CtrlEnBit];
    assign wr_valid = 32'(wr_sel) < NUM_PROJECTS;

    always_comb begin
        ctrl_rdata                           = '0;
        ctrl_rdata[CtrlSelLsb +: CtrlSelW]   = ctrl_sel_q;
        ctrl_rdata[CtrlEnBit]                = ctrl_en_q;
        status_rdata                         = '0;
        status_rdata[StatCurLsb +: CtrlSelW] = cur_q;
        status_rdata[StatOnBit]              = (state_q == StOn);
        status_rdata[StatBusyBit]            = (state_q == StGuard);
        guard_rdata                          = '0;
        guard_rdata[GuardW-1:0]              = guard_q;
    end

    // Register file next-state
    always_comb begin
        ctrl_sel_d = ctrl_sel_q;
        ctrl_en_d  = ctrl_en_q;
        guard_d    = guard_q;
        if (ctrl_we) begin
            ctrl_sel_d = wr_sel;
            ctrl_en_d  = wr_en;
        end
        if (guard_we) begin
            guard_d = wdata[GuardW-1:0];
        end
    end

    // FSM next-state; a CTRL write takes priority over the guard countdown.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cur_d   = cur_q;
        pend_d  = pend_q;

        unique case (state_q)
            StGuard: begin
                if (cnt_q == '0) begin
                    state_d = StOn;
                    cur_d   = pend_q;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: ;
        endcase

        if (ctrl_we) begin
            if (!wr_en || !wr_valid) begin
                state_d = StOff;
            end else if (!(state_q == StOn && cur_q == wr_sel)) begin
                // Re-selecting the already active project is a no-op to avoid a glitch.
                state_d = StGuard;
                pend_d  = wr_sel;
                cnt_d   = guard_q;
            end
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_q    <= StOff;
            cnt_q      <= '0;
            guard_q    <= GUARD_DEFAULT;
            ctrl_sel_q <= '0;
            ctrl_en_q  <= 1'b0;
            cur_q      <= '0;
            pend_q     <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            guard_q    <= guard_d;
            ctrl_sel_q <= ctrl_sel_d;
            ctrl_en_q  <= ctrl_en_d;
            cur_q      <= cur_d;
            pend_q     <= pend_d;
        end
    end

    always_comb begin
        active_o = '0;
        for (int unsigned i = 0; i < NUM_PROJECTS; i++) begin
            active_o[i] = (state_q == StOn) && (32'(cur_q) == i);
        end
    end

endmodule
